// File: rtl/lut_layer_scheduler.sv
// Purpose : time-multiplexed evaluator for one LogicNets layer; one shared,
//           runtime-programmable truth-table memory serves every neuron in turn.
// Latency : out_valid rises NUM_NEURONS+1 cycles after the accepting edge.
// Backpr. : in_ready/cfg_ready high only in IDLE; the result is held stable in
//           DONE until out_ready, so a stalled consumer stalls new inputs.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   cfg_we/addr/wdata table write, addr = {neuron, pattern}; honoured in IDLE only
//   cfg_ready         high when table writes are accepted (IDLE)
//   in_valid/ready    input vector handshake; in_data holds NUM_NEURONS patterns
//   out_valid/ready   result handshake; out_data bit n = neuron n output
//   busy              high whenever the scheduler is not IDLE
//
// Optional build macro LUT_CFG_READBACK_EN adds cfg_re / cfg_rdata / cfg_rvalid:
// a one-cycle-latency table readback, available in IDLE when no write is issued.

module lut_layer_scheduler #(
    parameter int NUM_NEURONS = 16,
    parameter int FANIN       = 8,
    parameter int NEURON_W    = $clog2(NUM_NEURONS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_we,
    input  logic [NEURON_W+FANIN-1:0]    cfg_addr,
    input  logic                         cfg_wdata,
    output logic                         cfg_ready,
`ifdef LUT_CFG_READBACK_EN
    input  logic                         cfg_re,
    output logic                         cfg_rdata,
    output logic                         cfg_rvalid,
`endif
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_NEURONS*FANIN-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_NEURONS-1:0]       out_data,
    output logic                         busy
);

    localparam int ADDR_W = NEURON_W + FANIN;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam logic [NEURON_W-1:0] LAST_CNT = NEURON_W'(NUM_NEURONS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    // shared truth-table storage; deliberately never reset
    logic                   mem [DEPTH];

    logic [FANIN-1:0]       pat_q [NUM_NEURONS];
    logic [NEURON_W-1:0]    cnt_q;
    logic [ADDR_W-1:0]      rd_addr;
    logic                   rd_bit_q;
    logic [NEURON_W-1:0]    rd_idx_q;
    logic                   rd_vld_q;
    logic [NUM_NEURONS-1:0] out_data_q;

    logic                   accept;
    logic                   cfg_wr;

    assign accept  = in_valid && in_ready;
    assign cfg_wr  = cfg_we && cfg_ready;
    assign rd_addr = {cnt_q, pat_q[cnt_q]};

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept)            state_d = S_RUN;
            S_RUN:   if (cnt_q == LAST_CNT) state_d = S_DRAIN;
            S_DRAIN:                        state_d = S_DONE;
            S_DONE:  if (out_ready)         state_d = S_IDLE;
            default:                        state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        cfg_ready = 1'b0;
        busy      = 1'b1;
        out_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready  = 1'b1;
                cfg_ready = 1'b1;
                busy      = 1'b0;
            end
            S_DONE:  out_valid = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Input latch: patterns are captured once so in_data may change freely
    // while the layer is being evaluated.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int n = 0; n < NUM_NEURONS; n++) begin
                pat_q[n] <= in_data[n*FANIN +: FANIN];
            end
        end
    end

    // ------------------------------------------------------------------
    // Table memory: writes only happen in IDLE and reads only in RUN, so a
    // read never races a write. A write on the accepting edge is visible to
    // the first lookup, which is issued one edge later.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (cfg_wr) begin
            mem[cfg_addr] <= cfg_wdata;
        end
        rd_bit_q <= mem[rd_addr];
    end

    // ------------------------------------------------------------------
    // Lookup sequencing and result assembly. rd_idx_q remembers which neuron
    // the registered read belongs to, so the bit lands one edge later; the
    // DRAIN cycle exists only to retire the last outstanding read.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            rd_idx_q   <= '0;
            rd_vld_q   <= 1'b0;
            out_data_q <= '0;
        end else begin
            rd_vld_q <= (state_q == S_RUN);
            rd_idx_q <= cnt_q;

            if (accept) begin
                cnt_q      <= '0;
                out_data_q <= '0;
            end else if (state_q == S_RUN && cnt_q != LAST_CNT) begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (rd_vld_q) begin
                out_data_q[rd_idx_q] <= rd_bit_q;
            end
        end
    end

    assign out_data = out_data_q;

`ifdef LUT_CFG_READBACK_EN
    // ------------------------------------------------------------------
    // Table readback: a request coinciding with a write is dropped so that
    // the returned bit is never ambiguous about old vs new contents.
    // ------------------------------------------------------------------
    logic cfg_rd_req;

    assign cfg_rd_req = cfg_re && !cfg_we && (state_q == S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_rvalid <= 1'b0;
            cfg_rdata  <= 1'b0;
        end else begin
            cfg_rvalid <= cfg_rd_req;
            if (cfg_rd_req) begin
                cfg_rdata <= mem[cfg_addr];
            end
        end
    end
`endif

endmodule
